// File: rtl/muntjac_clint.sv
`default_nettype none
// ============================================================================
// Module   : muntjac_clint
// Brief    : Core-local interruptor (msip / mtimecmp / mtime) behind a
//            single-beat 64-bit TileLink port with one registered response.
// Revision : 1.0 - initial release
// ============================================================================
module muntjac_clint #(
  parameter int NumHarts    = 1,
  parameter int AddrWidth   = 56,
  parameter int SourceWidth = 4,
  parameter int SinkWidth   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tick_i,

  input  logic                   tl_a_valid,
  output logic                   tl_a_ready,
  input  logic [2:0]             tl_a_opcode,
  input  logic [2:0]             tl_a_param,
  input  logic [2:0]             tl_a_size,
  input  logic [SourceWidth-1:0] tl_a_source,
  input  logic [AddrWidth-1:0]   tl_a_address,
  input  logic [7:0]             tl_a_mask,
  input  logic [63:0]            tl_a_data,

  output logic                   tl_d_valid,
  input  logic                   tl_d_ready,
  output logic [2:0]             tl_d_opcode,
  output logic [2:0]             tl_d_param,
  output logic [2:0]             tl_d_size,
  output logic [SourceWidth-1:0] tl_d_source,
  output logic [SinkWidth-1:0]   tl_d_sink,
  output logic                   tl_d_denied,
  output logic                   tl_d_corrupt,
  output logic [63:0]            tl_d_data,

  output logic [NumHarts-1:0]    irq_software_m_o,
  output logic [NumHarts-1:0]    irq_timer_m_o
);

  localparam logic [2:0]  c_OP_PUT_FULL     = 3'd0;
  localparam logic [2:0]  c_OP_PUT_PARTIAL  = 3'd1;
  localparam logic [2:0]  c_OP_GET          = 3'd4;
  localparam logic [2:0]  c_OP_ACK          = 3'd0;
  localparam logic [2:0]  c_OP_ACK_DATA     = 3'd1;
  // 64-bit word indices (byte offset >> 3) of the register blocks
  localparam logic [12:0] c_MTIMECMP_WORD   = 13'h0800;
  localparam logic [12:0] c_MTIME_WORD      = 13'h17FF;

  logic [NumHarts-1:0]        msip_q, msip_d;
  logic [NumHarts-1:0][63:0]  mtimecmp_q, mtimecmp_d;
  logic [63:0]                mtime_q, mtime_d;
  logic [NumHarts-1:0]        timer_q;

  logic                       d_valid_q;
  logic [2:0]                 d_opcode_q;
  logic [2:0]                 d_size_q;
  logic [SourceWidth-1:0]     d_source_q;
  logic                       d_denied_q;
  logic [63:0]                d_data_q;

  logic [12:0]                w_word;
  logic                       w_a_fire;
  logic                       w_d_fire;
  logic                       w_mapped;
  logic                       w_op_ok;
  logic                       w_denied;
  logic                       w_wr_en;
  logic [63:0]                w_rdata;
  logic [63:0]                w_bmask;

  // Address bits outside the decoded window and the A param carry no meaning here
  logic                       unused_bits;
  assign unused_bits = ^{tl_a_param, tl_a_address[AddrWidth-1:16], tl_a_address[2:0]};

  assign w_word     = tl_a_address[15:3];
  assign tl_a_ready = !d_valid_q || tl_d_ready;
  assign w_a_fire   = tl_a_valid && tl_a_ready;
  assign w_d_fire   = d_valid_q && tl_d_ready;

  assign w_op_ok  = (tl_a_opcode == c_OP_PUT_FULL) || (tl_a_opcode == c_OP_PUT_PARTIAL) ||
                    (tl_a_opcode == c_OP_GET);
  assign w_denied = !w_mapped || (tl_a_size > 3'd3) || !w_op_ok;
  assign w_wr_en  = w_a_fire && !w_denied && (tl_a_opcode != c_OP_GET);

  // Word decode and read mux; msip pairs share a word (even hart low half)
  always_comb begin
    w_mapped = 1'b0;
    w_rdata  = '0;
    for (int h = 0; h < NumHarts; h++) begin
      if (w_word == 13'(h / 2)) begin
        w_mapped               = 1'b1;
        w_rdata[32 * (h % 2)]  = msip_q[h];
      end
      if (w_word == c_MTIMECMP_WORD + 13'(h)) begin
        w_mapped = 1'b1;
        w_rdata  = mtimecmp_q[h];
      end
    end
    if (w_word == c_MTIME_WORD) begin
      w_mapped = 1'b1;
      w_rdata  = mtime_q;
    end
  end

  // Expand the byte mask to a bit mask for merging partial writes
  always_comb begin
    w_bmask = '0;
    for (int b = 0; b < 8; b++) begin
      w_bmask[8*b +: 8] = {8{tl_a_mask[b]}};
    end
  end

  // Register next state: software write wins over the mtime tick
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = tick_i ? mtime_q + 64'd1 : mtime_q;
    if (w_wr_en) begin
      for (int h = 0; h < NumHarts; h++) begin
        if ((w_word == 13'(h / 2)) && tl_a_mask[4 * (h % 2)]) begin
          msip_d[h] = tl_a_data[32 * (h % 2)];
        end
        if (w_word == c_MTIMECMP_WORD + 13'(h)) begin
          mtimecmp_d[h] = (mtimecmp_q[h] & ~w_bmask) | (tl_a_data & w_bmask);
        end
      end
      if (w_word == c_MTIME_WORD) begin
        mtime_d = (mtime_q & ~w_bmask) | (tl_a_data & w_bmask);
      end
    end
  end

  // Architectural timer/software-interrupt state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      msip_q     <= '0;
      mtimecmp_q <= '1;
      mtime_q    <= '0;
    end else begin
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
    end
  end

  // Registered timer compare of the current register values
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else begin
      for (int h = 0; h < NumHarts; h++) begin
        timer_q[h] <= (mtime_q >= mtimecmp_q[h]);
      end
    end
  end

  // Single-entry D response register; reload on A fire allows one beat per cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_valid_q  <= 1'b0;
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_denied_q <= 1'b0;
      d_data_q   <= '0;
    end else if (w_a_fire) begin
      d_valid_q  <= 1'b1;
      d_opcode_q <= (tl_a_opcode == c_OP_GET) ? c_OP_ACK_DATA : c_OP_ACK;
      d_size_q   <= tl_a_size;
      d_source_q <= tl_a_source;
      d_denied_q <= w_denied;
      d_data_q   <= ((tl_a_opcode == c_OP_GET) && !w_denied) ? w_rdata : '0;
    end else if (w_d_fire) begin
      d_valid_q  <= 1'b0;
    end
  end

  assign tl_d_valid   = d_valid_q;
  assign tl_d_opcode  = d_opcode_q;
  assign tl_d_param   = 3'd0;
  assign tl_d_size    = d_size_q;
  assign tl_d_source  = d_source_q;
  assign tl_d_sink    = '0;
  assign tl_d_denied  = d_denied_q;
  assign tl_d_corrupt = d_denied_q && (d_opcode_q == c_OP_ACK_DATA);
  assign tl_d_data    = d_data_q;

  assign irq_software_m_o = msip_q;
  assign irq_timer_m_o    = timer_q;

endmodule
`default_nettype wire

// File: tb/tb_muntjac_clint.sv
`default_nettype none
// ============================================================================
// Module   : tb_muntjac_clint
// Brief    : Self-checking bench for muntjac_clint (two harts) against a
//            byte-addressed register-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muntjac_clint;

  localparam int NH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        tl_a_valid = 1'b0;
  logic        tl_a_ready;
  logic [2:0]  tl_a_opcode = '0;
  logic [2:0]  tl_a_param = '0;
  logic [2:0]  tl_a_size = '0;
  logic [3:0]  tl_a_source = '0;
  logic [55:0] tl_a_address = '0;
  logic [7:0]  tl_a_mask = '0;
  logic [63:0] tl_a_data = '0;
  logic        tl_d_valid;
  logic        tl_d_ready = 1'b1;
  logic [2:0]  tl_d_opcode;
  logic [2:0]  tl_d_param;
  logic [2:0]  tl_d_size;
  logic [3:0]  tl_d_source;
  logic [0:0]  tl_d_sink;
  logic        tl_d_denied;
  logic        tl_d_corrupt;
  logic [63:0] tl_d_data;
  logic [NH-1:0] irq_sw;
  logic [NH-1:0] irq_tm;

  always #5 clk = ~clk;

  muntjac_clint #(.NumHarts(NH), .AddrWidth(56), .SourceWidth(4), .SinkWidth(1)) dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick),
    .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
    .tl_a_param(tl_a_param), .tl_a_size(tl_a_size), .tl_a_source(tl_a_source),
    .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask), .tl_a_data(tl_a_data),
    .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .tl_d_opcode(tl_d_opcode),
    .tl_d_param(tl_d_param), .tl_d_size(tl_d_size), .tl_d_source(tl_d_source),
    .tl_d_sink(tl_d_sink), .tl_d_denied(tl_d_denied), .tl_d_corrupt(tl_d_corrupt),
    .tl_d_data(tl_d_data), .irq_software_m_o(irq_sw), .irq_timer_m_o(irq_tm)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic        denied;
    logic        corrupt;
    logic [63:0] data;
  } resp_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural registers seen as a byte-addressed map
  logic [NH-1:0]       m_msip;
  logic [NH-1:0][63:0] m_cmp;
  logic [63:0]         m_mtime;
  logic [NH-1:0]       m_timer;
  logic                m_dvalid;

  function automatic logic [63:0] m_read(input logic [15:0] a, output bit mapped);
    logic [63:0] d;
    int off;
    d = '0;
    mapped = 0;
    for (int b = 0; b < 8; b++) begin
      off = int'({a[15:3], 3'b000}) + b;
      if (off < 4 * NH) begin
        mapped = 1;
        if (off % 4 == 0) d[8*b] = m_msip[off/4];
      end else if (off >= 'h4000 && off < 'h4000 + 8 * NH) begin
        mapped = 1;
        d[8*b +: 8] = m_cmp[(off - 'h4000) / 8][8*(off % 8) +: 8];
      end else if (off >= 'hBFF8 && off <= 'hBFFF) begin
        mapped = 1;
        d[8*b +: 8] = m_mtime[8*(off % 8) +: 8];
      end
    end
    return d;
  endfunction

  function automatic bit m_denied(input logic [2:0] op, input logic [2:0] size, input logic [15:0] a);
    bit mp;
    logic [63:0] unused_d;
    unused_d = m_read(a, mp);
    return !mp || (size > 3'd3) || !(op inside {3'd0, 3'd1, 3'd4});
  endfunction

  always @(posedge clk) begin : p_model
    logic [NH-1:0]       n_msip;
    logic [NH-1:0][63:0] n_cmp;
    logic [63:0]         n_mtime;
    logic                fire;
    logic                mt_wr;
    int                  off;
    if (rst) begin
      m_msip   <= '0;
      m_cmp    <= '1;
      m_mtime  <= '0;
      m_timer  <= '0;
      m_dvalid <= 1'b0;
    end else begin
      n_msip  = m_msip;
      n_cmp   = m_cmp;
      n_mtime = m_mtime;
      mt_wr   = 1'b0;
      fire    = tl_a_valid && (!m_dvalid || tl_d_ready);
      if (fire && tl_a_opcode != 3'd4 && !m_denied(tl_a_opcode, tl_a_size, tl_a_address[15:0])) begin
        if (tl_a_address[15:3] == 13'h17FF) mt_wr = 1'b1;
        for (int b = 0; b < 8; b++) begin
          if (tl_a_mask[b]) begin
            off = int'({tl_a_address[15:3], 3'b000}) + b;
            if (off < 4 * NH) begin
              if (off % 4 == 0) n_msip[off/4] = tl_a_data[8*b];
            end else if (off >= 'h4000 && off < 'h4000 + 8 * NH) begin
              n_cmp[(off - 'h4000) / 8][8*(off % 8) +: 8] = tl_a_data[8*b +: 8];
            end else if (off >= 'hBFF8 && off <= 'hBFFF) begin
              n_mtime[8*(off % 8) +: 8] = tl_a_data[8*b +: 8];
            end
          end
        end
      end
      if (!mt_wr && tick) n_mtime = m_mtime + 64'd1;
      for (int h = 0; h < NH; h++) m_timer[h] <= (m_mtime >= m_cmp[h]);
      m_msip   <= n_msip;
      m_cmp    <= n_cmp;
      m_mtime  <= n_mtime;
      m_dvalid <= fire ? 1'b1 : (tl_d_ready ? 1'b0 : m_dvalid);
    end
  end

  // Drive one request (expects acceptance on the next edge) and capture its response
  task automatic access(input logic [2:0] op, input logic [2:0] size, input logic [55:0] addr,
                        input logic [7:0] mask, input logic [63:0] data, input logic [3:0] src,
                        output resp_t r, output int lat);
    tl_a_valid = 1'b1; tl_a_opcode = op; tl_a_size = size; tl_a_address = addr;
    tl_a_mask = mask; tl_a_data = data; tl_a_source = src; tl_a_param = 3'($urandom);
    @(posedge clk); #1;
    tl_a_valid = 1'b0;
    lat = 1;
    while (!tl_d_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    r.op = tl_d_opcode; r.size = tl_d_size; r.src = tl_d_source;
    r.denied = tl_d_denied; r.corrupt = tl_d_corrupt; r.data = tl_d_data;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (tl_d_valid !== 1'b0) begin n_errors++; $display("FAIL reset_d_valid: got %b want 0", tl_d_valid); end
    n_checks++; if (tl_a_ready !== 1'b1) begin n_errors++; $display("FAIL reset_a_ready: got %b want 1", tl_a_ready); end
    n_checks++; if (irq_sw !== 2'b00) begin n_errors++; $display("FAIL reset_irq_sw: got %b want 00", irq_sw); end
    n_checks++; if (irq_tm !== 2'b00) begin n_errors++; $display("FAIL reset_irq_tm: got %b want 00", irq_tm); end
    n_checks++;
    if ({tl_d_opcode, tl_d_param, tl_d_size, tl_d_source, tl_d_sink, tl_d_denied, tl_d_corrupt, tl_d_data} !== '0) begin
      n_errors++; $display("FAIL reset_d_fields: got op=%h sz=%h src=%h den=%b cor=%b data=%h want all 0",
                           tl_d_opcode, tl_d_size, tl_d_source, tl_d_denied, tl_d_corrupt, tl_d_data);
    end
  endtask

  task automatic test_reset_reads;
    resp_t r; int lat;
    access(3'd4, 3'd3, 56'hBFF8, 8'hFF, '0, 4'd3, r, lat);
    n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL get_latency: got %0d want 1", lat); end
    n_checks++; if (r.op !== 3'd1) begin n_errors++; $display("FAIL get_mtime_opcode: got %0d want 1", r.op); end
    n_checks++; if (r.denied !== 1'b0) begin n_errors++; $display("FAIL get_mtime_denied: got %b want 0", r.denied); end
    n_checks++; if (r.data !== 64'h0) begin n_errors++; $display("FAIL get_mtime_reset: got %h want 0", r.data); end
    n_checks++; if (r.src !== 4'd3 || r.size !== 3'd3) begin n_errors++; $display("FAIL get_echo: got src=%0d size=%0d want 3/3", r.src, r.size); end
    access(3'd4, 3'd3, 56'h4000, 8'hFF, '0, 4'd4, r, lat);
    n_checks++; if (r.data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_errors++; $display("FAIL get_mtimecmp_reset: got %h want all-ones", r.data); end
  endtask

  task automatic test_timer;
    resp_t r; int lat; int s5; int si;
    access(3'd0, 3'd3, 56'h4000, 8'hFF, 64'd5, 4'd1, r, lat);
    n_checks++; if (r.op !== 3'd0 || r.denied !== 1'b0) begin n_errors++; $display("FAIL put_cmp_ack: got op=%0d den=%b want 0/0", r.op, r.denied); end
    tick = 1'b1;
    s5 = -1; si = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (m_mtime == 64'd5 && s5 < 0) s5 = i;
      if (irq_tm[0] && si < 0) si = i;
      n_checks++; if (irq_tm !== m_timer) begin n_errors++; $display("FAIL timer_track[%0d]: got %b want %b", i, irq_tm, m_timer); end
    end
    tick = 1'b0;
    n_checks++; if (si !== s5 + 1 || s5 < 0) begin n_errors++; $display("FAIL timer_rise_cycle: got sample %0d want %0d", si, s5 + 1); end
    access(3'd0, 3'd3, 56'h4000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd2, r, lat);
    n_checks++; if (irq_tm[0] !== 1'b1) begin n_errors++; $display("FAIL timer_fall_early: got %b want 1", irq_tm[0]); end
    idle(1);
    n_checks++; if (irq_tm[0] !== 1'b0) begin n_errors++; $display("FAIL timer_fall: got %b want 0", irq_tm[0]); end
  endtask

  task automatic test_msip;
    resp_t r; int lat;
    access(3'd1, 3'd3, 56'h0, 8'hF0, 64'h0000_0001_0000_0000, 4'd5, r, lat);
    n_checks++; if (irq_sw !== 2'b10) begin n_errors++; $display("FAIL msip_irq: got %b want 10", irq_sw); end
    access(3'd4, 3'd3, 56'h0, 8'hFF, '0, 4'd6, r, lat);
    n_checks++; if (r.data !== 64'h0000_0001_0000_0000) begin n_errors++; $display("FAIL msip_readback: got %h want 0000000100000000", r.data); end
  endtask

  task automatic test_mtime_wrap;
    resp_t r; int lat;
    tick = 1'b1;
    access(3'd0, 3'd3, 56'hBFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd7, r, lat);
    tick = 1'b0;
    access(3'd4, 3'd3, 56'hBFF8, 8'hFF, '0, 4'd8, r, lat);
    n_checks++; if (r.data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_errors++; $display("FAIL mtime_write_wins: got %h want all-ones", r.data); end
    tick = 1'b1;
    idle(1);
    tick = 1'b0;
    access(3'd4, 3'd3, 56'hBFF8, 8'hFF, '0, 4'd9, r, lat);
    n_checks++; if (r.data !== 64'h0) begin n_errors++; $display("FAIL mtime_wrap: got %h want 0", r.data); end
  endtask

  task automatic test_backpressure;
    resp_t r; int lat; bit mp; logic [63:0] exp;
    idle(1);
    tl_d_ready = 1'b0;
    exp = m_read(16'hBFF8, mp);
    access(3'd4, 3'd3, 56'hBFF8, 8'hFF, '0, 4'd9, r, lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if (tl_a_ready !== 1'b0) begin n_errors++; $display("FAIL stall_a_ready[%0d]: got %b want 0", i, tl_a_ready); end
      n_checks++;
      if (tl_d_valid !== 1'b1 || tl_d_data !== exp || tl_d_source !== 4'd9 || tl_d_opcode !== 3'd1) begin
        n_errors++; $display("FAIL stall_hold[%0d]: got v=%b data=%h src=%0d op=%0d want 1/%h/9/1",
                             i, tl_d_valid, tl_d_data, tl_d_source, tl_d_opcode, exp);
      end
    end
    tl_d_ready = 1'b1;
  endtask

  task automatic test_back_to_back;
    bit mp; logic [63:0] exp; logic [15:0] lo;
    for (int i = 0; i < 8; i++) begin
      case ($urandom % 4)
        0: lo = 16'h0000;
        1: lo = 16'h4000;
        2: lo = 16'h4008;
        default: lo = 16'hBFF8;
      endcase
      tl_a_valid = 1'b1; tl_a_opcode = 3'd4; tl_a_size = 3'd3; tl_a_mask = 8'hFF;
      tl_a_address = {40'($urandom), lo}; tl_a_source = 4'(i);
      exp = m_read(lo, mp);
      @(posedge clk); #1;
      n_checks++; if (tl_a_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, tl_a_ready); end
      n_checks++;
      if (tl_d_valid !== 1'b1 || tl_d_source !== 4'(i) || tl_d_data !== exp) begin
        n_errors++; $display("FAIL b2b_resp[%0d]: got v=%b src=%0d data=%h want 1/%0d/%h", i, tl_d_valid, tl_d_source, tl_d_data, i, exp);
      end
    end
    tl_a_valid = 1'b0;
  endtask

  task automatic test_denied;
    resp_t r; int lat; logic [63:0] mt0;
    access(3'd4, 3'd3, 56'h8000, 8'hFF, '0, 4'd1, r, lat);
    n_checks++; if (r.op !== 3'd1 || r.denied !== 1'b1 || r.corrupt !== 1'b1) begin n_errors++; $display("FAIL deny_get: got op=%0d den=%b cor=%b want 1/1/1", r.op, r.denied, r.corrupt); end
    access(3'd0, 3'd3, 56'h8000, 8'hFF, 64'hDEAD, 4'd2, r, lat);
    n_checks++; if (r.op !== 3'd0 || r.denied !== 1'b1 || r.corrupt !== 1'b0) begin n_errors++; $display("FAIL deny_put: got op=%0d den=%b cor=%b want 0/1/0", r.op, r.denied, r.corrupt); end
    mt0 = m_mtime;
    access(3'd0, 3'd4, 56'hBFF8, 8'hFF, 64'h1234, 4'd3, r, lat);
    n_checks++; if (r.denied !== 1'b1) begin n_errors++; $display("FAIL deny_put_size4: got %b want 1", r.denied); end
    access(3'd4, 3'd4, 56'hBFF8, 8'hFF, '0, 4'd4, r, lat);
    n_checks++; if (r.denied !== 1'b1 || r.corrupt !== 1'b1) begin n_errors++; $display("FAIL deny_get_size4: got den=%b cor=%b want 1/1", r.denied, r.corrupt); end
    access(3'd2, 3'd3, 56'h4000, 8'hFF, 64'h0, 4'd5, r, lat);
    n_checks++; if (r.op !== 3'd0 || r.denied !== 1'b1) begin n_errors++; $display("FAIL deny_opcode: got op=%0d den=%b want 0/1", r.op, r.denied); end
    access(3'd4, 3'd3, 56'hBFF8, 8'hFF, '0, 4'd6, r, lat);
    n_checks++; if (r.data !== mt0) begin n_errors++; $display("FAIL deny_no_change: got %h want %h", r.data, mt0); end
  endtask

  task automatic test_random;
    resp_t r; int lat; bit mp; bit den; logic [63:0] exp;
    logic [15:0] lo; logic [2:0] op; logic [2:0] sz; logic [3:0] src; logic [7:0] mask; logic [63:0] data;
    for (int i = 0; i < 60; i++) begin
      case ($urandom % 8)
        0: lo = 16'h0000;
        1: lo = 16'h0004;
        2: lo = 16'h4000;
        3: lo = 16'h4008;
        4: lo = 16'hBFF8;
        5: lo = 16'hBFFC;
        6: lo = 16'h8000;
        default: lo = 16'($urandom);
      endcase
      case ($urandom % 6)
        0: op = 3'd0;
        1: op = 3'd1;
        2, 3: op = 3'd4;
        4: op = 3'd2;
        default: op = 3'd5;
      endcase
      sz   = ($urandom % 4 == 0) ? 3'($urandom % 5) : 3'd3;
      src  = 4'($urandom);
      mask = 8'($urandom);
      data = {$urandom, $urandom};
      tick = 1'($urandom);
      den  = m_denied(op, sz, lo);
      exp  = m_read(lo, mp);
      access(op, sz, {40'($urandom), lo}, mask, data, src, r, lat);
      n_checks++;
      if (lat !== 1 || r.op !== ((op == 3'd4) ? 3'd1 : 3'd0) || r.denied !== den || r.src !== src || r.size !== sz ||
          r.corrupt !== (den && op == 3'd4)) begin
        n_errors++; $display("FAIL rnd_hdr[%0d]: got lat=%0d op=%0d den=%b src=%0d sz=%0d cor=%b want op_in=%0d den=%b src=%0d sz=%0d",
                             i, lat, r.op, r.denied, r.src, r.size, r.corrupt, op, den, src, sz);
      end
      if (op == 3'd4 && !den) begin
        n_checks++; if (r.data !== exp) begin n_errors++; $display("FAIL rnd_data[%0d] addr=%h: got %h want %h", i, lo, r.data, exp); end
      end
      n_checks++; if (tl_d_param !== 3'd0 || tl_d_sink !== 1'b0) begin n_errors++; $display("FAIL rnd_const[%0d]: got param=%0d sink=%0d want 0/0", i, tl_d_param, tl_d_sink); end
      n_checks++; if (irq_sw !== m_msip || irq_tm !== m_timer) begin n_errors++; $display("FAIL rnd_irq[%0d]: got sw=%b tm=%b want %b/%b", i, irq_sw, irq_tm, m_msip, m_timer); end
    end
    tick = 1'b0;
  endtask

  task automatic test_reset_midflight;
    resp_t r; int lat;
    idle(1);
    tl_d_ready = 1'b0;
    access(3'd4, 3'd3, 56'hBFF8, 8'hFF, '0, 4'd11, r, lat);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tl_d_ready = 1'b1;
    n_checks++; if (tl_d_valid !== 1'b0 || tl_a_ready !== 1'b1) begin n_errors++; $display("FAIL midreset_drop: got v=%b rdy=%b want 0/1", tl_d_valid, tl_a_ready); end
    idle(2);
    n_checks++; if (tl_d_valid !== 1'b0 || irq_sw !== 2'b00) begin n_errors++; $display("FAIL midreset_quiet: got v=%b sw=%b want 0/00", tl_d_valid, irq_sw); end
  endtask

  initial begin
    test_reset();
    test_reset_reads();
    test_timer();
    test_msip();
    test_mtime_wrap();
    test_backpressure();
    test_back_to_back();
    test_denied();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
